// File: rtl/reaction_timer_core.sv
// Reaction-test datapath: tick divider, PRNG-scaled stimulus delay, reaction count-up,
// false-start detection, best-score tracking and averaging over TRIALS counted trials.
module reaction_timer_core #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 1000,
  parameter int PRNG_W    = 8,
  parameter int MIN_DELAY = 3000,
  parameter int MAX_DELAY = 6000,
  parameter int SCORE_W   = 14,
  parameter int TRIALS    = 4
) (
  input  logic                      clk,
  input  logic                      iResetn,
  input  logic [PRNG_W-1:0]         iPRNG,
  input  logic                      iStart,
  input  logic                      iResponse,
  output logic                      oScreen,
  output logic                      oBusy,
  output logic                      oFalseStart,
  output logic                      oScoreValid,
  output logic [SCORE_W-1:0]        oCurrentScore,
  output logic [SCORE_W-1:0]        oHighScore,
  output logic                      oAvgValid,
  output logic [SCORE_W-1:0]        oAverageScore,
  output logic [$clog2(TRIALS):0]   oTrialIdx
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int DIV_W  = $clog2(DIV);
  localparam int LOG_T  = $clog2(TRIALS);
  localparam int IDX_W  = LOG_T + 1;
  localparam int SUM_W  = SCORE_W + LOG_T;
  localparam int DLY_W  = $clog2(MAX_DELAY + 1);
  localparam int SPAN   = MAX_DELAY - MIN_DELAY;
  localparam int PROD_W = PRNG_W + $clog2(SPAN + 1);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [PROD_W-1:0]  SPAN_P    = PROD_W'(SPAN);
  localparam logic [PROD_W-1:0]  DEN_P     = PROD_W'((2 ** PRNG_W) - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_REACT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FALSE = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PRNG_W-1:0]  prng_q, prng_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [SCORE_W-1:0] react_q, react_d;
  logic               resp_d1_q;
  logic               false_q, false_d;
  logic [SCORE_W-1:0] cur_q, cur_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [SCORE_W-1:0] avg_q, avg_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               score_vld_q, score_vld_d;
  logic               avg_vld_q, avg_vld_d;

  logic               tick;
  logic               resp_rise;
  logic               finish;
  logic               timeout;
  logic [SCORE_W-1:0] cap;
  logic [SUM_W-1:0]   sum_next;
  logic [PROD_W-1:0]  prod;
  logic [PROD_W-1:0]  quot;
  logic [DLY_W-1:0]   delay_calc;

  assign tick      = (div_q == DIV_W'(DIV - 1));
  assign resp_rise = iResponse & ~resp_d1_q;

  // Product kept at full width so the scale is exact before the divide.
  assign prod       = PROD_W'(prng_q) * SPAN_P;
  assign quot       = prod / DEN_P;
  assign delay_calc = DLY_W'(MIN_DELAY) + DLY_W'(quot);

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + 1'b1;
    prng_d      = prng_q;
    dly_d       = dly_q;
    react_d     = react_q;
    false_d     = false_q;
    cur_d       = cur_q;
    high_d      = high_q;
    avg_d       = avg_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    score_vld_d = 1'b0;
    avg_vld_d   = 1'b0;
    finish      = 1'b0;
    timeout     = 1'b0;
    cap         = '0;
    sum_next    = '0;
    case (state_q)
      S_IDLE, S_FALSE: begin
        if (iStart) begin
          state_d = S_LOAD;
          false_d = 1'b0;
          prng_d  = iPRNG;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
        dly_d   = delay_calc;
        div_d   = '0;
      end
      S_WAIT: begin
        // A press on the final tick still counts as a false start.
        if (resp_rise) begin
          state_d = S_FALSE;
          false_d = 1'b1;
        end else if (tick) begin
          if (dly_q <= DLY_W'(1)) begin
            state_d = S_REACT;
            div_d   = '0;
            react_d = '0;
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
      end
      S_REACT: begin
        if (resp_rise) begin
          finish = 1'b1;
          cap    = react_q;
        end else if (tick) begin
          if (react_q == SCORE_MAX - 1'b1) begin
            finish  = 1'b1;
            timeout = 1'b1;
            cap     = SCORE_MAX;
          end else begin
            react_d = react_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Scores publish on entry to DONE so the pulses coincide with the DONE cycle.
    if (finish) begin
      state_d     = S_DONE;
      cur_d       = cap;
      score_vld_d = 1'b1;
      if (!timeout && (cap < high_q)) high_d = cap;
      sum_next = sum_q + SUM_W'(cap);
      if (idx_q == IDX_W'(TRIALS - 1)) begin
        avg_d     = SCORE_W'(sum_next >> LOG_T);
        avg_vld_d = 1'b1;
        sum_d     = '0;
        idx_d     = '0;
      end else begin
        sum_d = sum_next;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      prng_q      <= '0;
      dly_q       <= '0;
      react_q     <= '0;
      resp_d1_q   <= 1'b0;
      false_q     <= 1'b0;
      cur_q       <= '0;
      high_q      <= SCORE_MAX;
      avg_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      score_vld_q <= 1'b0;
      avg_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      prng_q      <= prng_d;
      dly_q       <= dly_d;
      react_q     <= react_d;
      resp_d1_q   <= iResponse;
      false_q     <= false_d;
      cur_q       <= cur_d;
      high_q      <= high_d;
      avg_q       <= avg_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      score_vld_q <= score_vld_d;
      avg_vld_q   <= avg_vld_d;
    end
  end

  assign oScreen       = (state_q == S_REACT);
  assign oBusy         = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_REACT);
  assign oFalseStart   = false_q;
  assign oScoreValid   = score_vld_q;
  assign oCurrentScore = cur_q;
  assign oHighScore    = high_q;
  assign oAvgValid     = avg_vld_q;
  assign oAverageScore = avg_q;
  assign oTrialIdx     = idx_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core: expected scores and averages are queued by the
// stimulus and consumed by a monitor whenever the DUT pulses oScoreValid / oAvgValid.
module tb_reaction_timer_core;

  logic       clk = 1'b0;
  logic       iResetn;
  logic [7:0] iPRNG;
  logic       iStart;
  logic       iResponse;
  logic       oScreen, oBusy, oFalseStart, oScoreValid, oAvgValid;
  logic [7:0] oCurrentScore, oHighScore, oAverageScore;
  logic [2:0] oTrialIdx;

  reaction_timer_core #(
    .CLK_HZ(1000), .TICK_HZ(100), .PRNG_W(8), .MIN_DELAY(30),
    .MAX_DELAY(60), .SCORE_W(8), .TRIALS(4)
  ) dut (
    .clk(clk), .iResetn(iResetn), .iPRNG(iPRNG), .iStart(iStart),
    .iResponse(iResponse), .oScreen(oScreen), .oBusy(oBusy),
    .oFalseStart(oFalseStart), .oScoreValid(oScoreValid),
    .oCurrentScore(oCurrentScore), .oHighScore(oHighScore),
    .oAvgValid(oAvgValid), .oAverageScore(oAverageScore), .oTrialIdx(oTrialIdx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int high;
    int idx;
  } score_exp_t;

  score_exp_t score_q[$];
  int         avg_q[$];
  score_exp_t se;
  int         ae;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (iResetn && oScoreValid) begin
      if (score_q.size() == 0) begin
        check("unexpected_score_valid", 32'd1, 32'd0);
      end else begin
        se = score_q.pop_front();
        check("score", 32'(oCurrentScore), 32'(se.score));
        check("high_score", 32'(oHighScore), 32'(se.high));
        check("trial_idx", 32'(oTrialIdx), 32'(se.idx));
      end
    end
    if (iResetn && oAvgValid) begin
      if (avg_q.size() == 0) begin
        check("unexpected_avg_valid", 32'd1, 32'd0);
      end else begin
        ae = avg_q.pop_front();
        check("average", 32'(oAverageScore), 32'(ae));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Vector table. mode: 0 normal press, 1 button held across start, 2 timeout, 3 false start.
  localparam int NV = 9;
  int v_prng  [NV] = '{0,   255, 128, 128, 0,  0,   0, 0, 255};
  int v_delay [NV] = '{30,  60,  45,  45,  30, 30,  30, 30, 60};
  int v_score [NV] = '{5,   7,   0,   6,   9,  255, 5, 3, 11};
  int v_high  [NV] = '{5,   5,   5,   5,   5,  5,   5, 3, 3};
  int v_idx   [NV] = '{1,   2,   2,   3,   0,  1,   2, 3, 0};
  int v_avg   [NV] = '{-1,  -1,  -1,  -1,  6,  -1,  -1, -1, 68};
  int v_mode  [NV] = '{0,   0,   3,   1,   0,  2,   0, 0, 0};

  task automatic start_trial(input int prng);
    iPRNG  = 8'(prng);
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    check("busy_after_start", 32'(oBusy), 32'd1);
    check("false_cleared_on_start", 32'(oFalseStart), 32'd0);
  endtask

  task automatic wait_screen(input int exp_cycles);
    int k;
    k = 1;
    while (!oScreen && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("screen_rise_cycle", 32'(k), 32'(exp_cycles));
  endtask

  initial begin
    iResetn   = 1'b0;
    iStart    = 1'b0;
    iResponse = 1'b0;
    iPRNG     = '0;
    repeat (3) @(negedge clk);
    check("rst_screen", 32'(oScreen), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_false", 32'(oFalseStart), 32'd0);
    check("rst_cur", 32'(oCurrentScore), 32'd0);
    check("rst_high", 32'(oHighScore), 32'd255);
    check("rst_avg", 32'(oAverageScore), 32'd0);
    check("rst_idx", 32'(oTrialIdx), 32'd0);
    iResetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (v_mode[i] == 3) begin
        start_trial(v_prng[i]);
        repeat (100) @(negedge clk);
        iResponse = 1'b1;
        @(negedge clk);
        check("false_start_flag", 32'(oFalseStart), 32'd1);
        check("false_start_busy", 32'(oBusy), 32'd0);
        repeat (5) @(negedge clk);
        check("false_start_idx", 32'(oTrialIdx), 32'(v_idx[i]));
        check("false_start_screen", 32'(oScreen), 32'd0);
        iResponse = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        if (v_mode[i] == 1) begin
          iResponse = 1'b1;
          repeat (2) @(negedge clk);
        end
        start_trial(v_prng[i]);
        wait_screen(2 + 10 * v_delay[i]);
        score_q.push_back('{v_score[i], v_high[i], v_idx[i]});
        if (v_avg[i] >= 0) avg_q.push_back(v_avg[i]);
        if (v_mode[i] == 2) begin
          int k;
          k = 0;
          while (!oScoreValid && k < 3000) begin
            @(negedge clk);
            k++;
          end
          check("timeout_cycles", 32'(k), 32'd2550);
        end else if (v_mode[i] == 1) begin
          check("held_no_false_start", 32'(oFalseStart), 32'd0);
          repeat (30) @(negedge clk);
          iResponse = 1'b0;
          repeat (10 * v_score[i] + 5 - 30) @(negedge clk);
          iResponse = 1'b1;
        end else begin
          repeat (10 * v_score[i] + 5) @(negedge clk);
          iResponse = 1'b1;
        end
        repeat (3) @(negedge clk);
        iResponse = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_done", 32'(oBusy), 32'd0);
      end
    end

    // Asynchronous reset in the middle of REACT.
    start_trial(0);
    wait_screen(302);
    repeat (20) @(negedge clk);
    #2 iResetn = 1'b0;
    #1;
    check("async_rst_screen", 32'(oScreen), 32'd0);
    check("async_rst_busy", 32'(oBusy), 32'd0);
    check("async_rst_high", 32'(oHighScore), 32'd255);
    check("async_rst_cur", 32'(oCurrentScore), 32'd0);
    check("async_rst_avg", 32'(oAverageScore), 32'd0);
    check("async_rst_idx", 32'(oTrialIdx), 32'd0);
    @(negedge clk);
    iResetn = 1'b1;
    repeat (10) @(negedge clk);
    check("after_rst_idle", 32'(oBusy), 32'd0);
    check("score_queue_drained", 32'(score_q.size()), 32'd0);
    check("avg_queue_drained", 32'(avg_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
- Parametrised next generation of the reaction-test datapath. One block holds the tick divider, random-delay scaler, delay countdown, reaction count-up, false-start detection, best-score tracking and multi-trial averaging.
- Sits between the game FSM/PRNG and the display/score logic.
- Drives the stimulus (screen) signal and publishes current, best and average scores.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1000, score/delay tick rate. DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.
- PRNG_W, 8, width of the random input.
- MIN_DELAY, 3000, minimum stimulus delay in ticks.
- MAX_DELAY, 6000, maximum stimulus delay in ticks. Must be > MIN_DELAY.
- SCORE_W, 14, score width in ticks. SCORE_MAX = 2^SCORE_W - 1.
- TRIALS, 4, trials per average. Must be a power of 2, ≥ 1.

Ports:
- clk  in  1  system clock
- iResetn  in  1  asynchronous active-low reset
- iPRNG  in  PRNG_W  random value, sampled on accepted start
- iStart  in  1  start-trial request, level sampled each clk
- iResponse  in  1  player button, synchronous level
- oScreen  out  1  stimulus on, high during REACT only
- oBusy  out  1  high in LOAD/WAIT/REACT
- oFalseStart  out  1  set on false start, cleared on next accepted start
- oScoreValid  out  1  one-cycle pulse when oCurrentScore updates
- oCurrentScore  out  SCORE_W  last trial score
- oHighScore  out  SCORE_W  best (lowest) valid score
- oAvgValid  out  1  one-cycle pulse when oAverageScore updates
- oAverageScore  out  SCORE_W  mean of last TRIALS counted trials
- oTrialIdx  out  clog2(TRIALS)+1  counted trials in current set

Behaviour:
- Reset (async on iResetn low, released synchronously to clk):
  - state=IDLE; all pulses, oScreen, oBusy and oFalseStart = 0.
  - oCurrentScore = 0, oAverageScore = 0, oHighScore = SCORE_MAX.
  - sum = 0, oTrialIdx = 0, tick divider = 0.
  - Reset mid-trial aborts the trial with no score update.
- Tick divider: counts 0..DIV-1. A tick is the cycle where the count equals DIV-1. The divider is forced to 0 on entry to WAIT and on entry to REACT, so durations are exact multiples of DIV cycles.
- Response edge: resp_rise = iResponse & ~iResponse_d1. Only rising edges count; a button held from earlier never registers.
- IDLE:
  - iStart=1 → LOAD; clear oFalseStart.
  - Latch delay = MIN_DELAY + (iPRNG*(MAX_DELAY-MIN_DELAY))/(2^PRNG_W-1), using a full-width intermediate with no truncation before the divide.
  - iStart has priority over a simultaneous resp_rise.
- LOAD: exactly one cycle, registers the delay → WAIT.
- WAIT:
  - Delay counter decrements on each tick. After `delay` ticks → REACT.
  - resp_rise in WAIT → FALSE: oFalseStart=1, no score, sum and oTrialIdx unchanged.
  - resp_rise on the same cycle as the final tick counts as a false start.
- REACT:
  - oScreen=1. Reaction counter starts at 0 and increments on each tick.
  - resp_rise → DONE, capturing the counter value at that cycle, before that cycle's increment.
  - Counter reaching SCORE_MAX → DONE as a timeout, with captured score = SCORE_MAX.
- DONE (one cycle), then → IDLE:
  - oCurrentScore=captured, oScoreValid=1.
  - If not a timeout and captured < oHighScore, oHighScore=captured. Ties leave it unchanged.
  - sum += captured; oTrialIdx += 1. Timeouts count as trials.
  - If oTrialIdx reaches TRIALS: oAverageScore = sum>>clog2(TRIALS), computed including this trial; oAvgValid=1; sum=0; oTrialIdx=0.
  - sum width = SCORE_W + clog2(TRIALS); it never overflows.
- FALSE: oFalseStart held. iStart → LOAD, same as IDLE. Otherwise stays.
- iStart in LOAD/WAIT/REACT/DONE is ignored.
- oBusy = state ∈ {LOAD, WAIT, REACT}.

Test Plan:
- Bench params: CLK_HZ=1000, TICK_HZ=100 (DIV=10), MIN_DELAY=30, MAX_DELAY=60, SCORE_W=8, TRIALS=4.
- iPRNG=0, iStart for 1 cycle at cycle 0 → oScreen rises at cycle 302: 1 IDLE + 1 LOAD + 300 WAIT cycles. iPRNG=255 → 600 WAIT cycles. iPRNG=128 → delay 45 ticks (450 cycles).
- iResponse rises 55 cycles after oScreen rises → oCurrentScore=5, one-cycle oScoreValid, oHighScore 255→5. A later trial scoring 7 leaves oHighScore=5.
- iResponse rises in WAIT → oFalseStart=1, oTrialIdx unchanged, no oScoreValid. Next iStart clears oFalseStart. iResponse held high across the oScreen rise → no score until release and re-press.
- Four trials scoring 5, 6, 7, 9 → oAvgValid pulses once on the 4th DONE, oAverageScore=6 (27>>2), oTrialIdx returns to 0.
- No response in REACT → captured score 255 after 2550 cycles, oHighScore unchanged, counted in oTrialIdx. iResetn low mid-REACT → oScreen=0 immediately (async), all outputs at reset values.
